// File: rtl/mult_hilo_unit_pkg.sv
// Shared definitions for the MULT/MULTU HI/LO unit and its sign/magnitude helper.
package mult_hilo_unit_pkg;

    localparam int DATA_W          = 16;
    localparam int PROD_W          = 32;
    // Default cycles from the multiplier start pulse until its product is valid.
    localparam int MUL_LATENCY_DEF = 34;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/mult_hilo_unit_sign_mag.sv
// Combinational absolute value of a 16-bit operand plus its effective sign.
// The most negative value 0x8000 maps to magnitude 0x8000, read as unsigned.
module sign_mag16
    import mult_hilo_unit_pkg::*;
(
    input  logic [DATA_W-1:0] val,
    input  logic              is_signed,
    output logic [DATA_W-1:0] mag,
    output logic              sign
);

    assign sign = is_signed & val[DATA_W-1];
    assign mag  = sign ? (~val + 1'b1) : val;

endmodule

// File: rtl/mult_hilo_unit.sv
// MULT/MULTU front/back end around the sequential 16x16 shift-add multiplier.
// Operands are converted to magnitudes, the multiplier is started and timed with
// a fixed latency counter, then the sign is re-applied and the product written
// to HI/LO. Optional build macro MULT_ACC_EN adds the acc input (MADD/MADDU).
module mult_hilo_unit
    import mult_hilo_unit_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,  // min 2
    parameter int CNT_W       = 6                 // 2**CNT_W must exceed MUL_LATENCY
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
`ifdef MULT_ACC_EN
    input  logic              acc,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    output logic              mul_st,
    input  logic [PROD_W-1:0] mul_p
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic [DATA_W-1:0]  mag_a, mag_b;
    logic               sign_a, sign_b;
    logic [PROD_W-1:0]  result;
    logic [PROD_W-1:0]  hilo_n;
    logic               accept;
`ifdef MULT_ACC_EN
    logic               acc_q;
`endif

    sign_mag16 u_sign_a (.val(op_a), .is_signed(signed_op), .mag(mag_a), .sign(sign_a));
    sign_mag16 u_sign_b (.val(op_b), .is_signed(signed_op), .mag(mag_b), .sign(sign_b));

    assign accept = (state == IDLE) && req;

    // Control outputs decode directly from the state, so reset clears them too.
    assign mul_st = (state == START);
    assign done   = (state == CAPTURE);
    assign busy   = (state != IDLE);

    // Re-apply the sign (32-bit wrap keeps a negated zero at zero) and optionally accumulate.
    always_comb begin
        result = neg ? (~mul_p + 1'b1) : mul_p;
        hilo_n = result;
`ifdef MULT_ACC_EN
        if (acc_q) hilo_n = {hi, lo} + result;
`endif
    end

    // Next-state logic: one start cycle, a fixed wait, then a single capture cycle.
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        state_n = state;
        unique case (state)
            IDLE:    if (req) state_n = START;
            START:   state_n = WAIT;
            WAIT:    if (cnt == '0) state_n = CAPTURE;
            CAPTURE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    // Latency counter: loaded in START, counts down through WAIT.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                             cnt <= '0;
        else if (state == START)               cnt <= CNT_LOAD;
        else if (state == WAIT && cnt != '0)   cnt <= cnt - 1'b1;
    end

    // Operand latch: magnitudes and result sign are held for the whole operation.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mul_a <= '0;
            mul_b <= '0;
            neg   <= 1'b0;
`ifdef MULT_ACC_EN
            acc_q <= 1'b0;
`endif
        end else if (accept) begin
            mul_a <= mag_a;
            mul_b <= mag_b;
            neg   <= sign_a ^ sign_b;
`ifdef MULT_ACC_EN
            acc_q <= acc;
`endif
        end
    end

    // HI/LO registers: written at the end of the CAPTURE cycle, held otherwise.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == CAPTURE) begin
            hi <= hilo_n[PROD_W-1:DATA_W];
            lo <= hilo_n[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit with a behavioural model of the shift-add multiplier.
module tb_mult_hilo_unit;

    localparam int L = 34;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req, signed_op;
    logic [15:0] op_a, op_b;
    logic        acc;
    logic        busy, done, mul_st;
    logic [15:0] hi, lo, mul_a, mul_b;
    logic [31:0] mul_p;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    mult_hilo_unit #(.MUL_LATENCY(L), .CNT_W(6)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .signed_op(signed_op),
        .op_a(op_a), .op_b(op_b),
`ifdef MULT_ACC_EN
        .acc(acc),
`endif
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .mul_a(mul_a), .mul_b(mul_b), .mul_st(mul_st), .mul_p(mul_p)
    );

    // Multiplier model: product appears exactly L edges after the start pulse is sampled.
    logic [31:0] m_prod;
    int          m_cnt;
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mul_p <= 32'h0;
            m_cnt <= 0;
        end else if (mul_st) begin
            m_prod <= {16'h0, mul_a} * {16'h0, mul_b};
            mul_p  <= 32'hDEAD_BEEF;
            m_cnt  <= L;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) mul_p <= m_prod;
        end
    end

    // Pulse counters sampled mid-cycle.
    int st_count, done_count;
    always @(negedge Clk) begin
        if (mul_st) st_count++;
        if (done)   done_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request and wait for done. inject_at >= 0 pulses a stray req at that cycle.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic ac, input int inject_at,
                         input logic [15:0] exp_ma, input logic [15:0] exp_mb,
                         input logic [31:0] exp_hilo);
        int  lat;
        bit  seen;
        @(negedge Clk);
        req = 1'b1; signed_op = s; op_a = a; op_b = b; acc = ac;
        st_count = 0; done_count = 0;
        @(posedge Clk);
        lat = 0; seen = 0;
        while (!seen && lat < 200) begin
            @(negedge Clk);
            if (lat == 0) begin
                check({tag, " busy"}, {31'h0, busy}, 32'h1);
                req = 1'b0; op_a = 16'h7777; op_b = 16'h1234; signed_op = ~s; acc = 1'b0;
            end else if (lat == 1) begin
                check({tag, " mul_a"}, {16'h0, mul_a}, {16'h0, exp_ma});
                check({tag, " mul_b"}, {16'h0, mul_b}, {16'h0, exp_mb});
            end
            req = (lat == inject_at);
            seen = done;
            @(posedge Clk);
            lat++;
        end
        req = 1'b0;
        check({tag, " latency"}, lat, L + 2);
        #1;
        check({tag, " hilo"}, {hi, lo}, exp_hilo);
        repeat (3) @(negedge Clk);
        check({tag, " st pulses"}, st_count, 1);
        check({tag, " done pulses"}, done_count, 1);
        check({tag, " idle"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        Reset = 1'b1; req = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0; acc = 1'b0;
        #1;
        check("reset busy",   {31'h0, busy},   32'h0);
        check("reset done",   {31'h0, done},   32'h0);
        check("reset mul_st", {31'h0, mul_st}, 32'h0);
        check("reset hilo",   {hi, lo},        32'h0);
        check("reset mul_ab", {mul_a, mul_b},  32'h0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        do_op("multu 3x5",       16'h0003, 16'h0005, 1'b0, 1'b0, -1, 16'h0003, 16'h0005, 32'h0000_000F);
        do_op("mult -2x3",       16'hFFFE, 16'h0003, 1'b1, 1'b0, -1, 16'h0002, 16'h0003, 32'hFFFF_FFFA);
        do_op("multu ffff^2",    16'hFFFF, 16'hFFFF, 1'b0, 1'b0, -1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        do_op("mult 8000^2",     16'h8000, 16'h8000, 1'b1, 1'b0, -1, 16'h8000, 16'h8000, 32'h4000_0000);
        do_op("mult -3x-5",      16'hFFFD, 16'hFFFB, 1'b1, 1'b0, -1, 16'h0003, 16'h0005, 32'h0000_000F);
        do_op("mult 7x-7",       16'h0007, 16'hFFF9, 1'b1, 1'b0, -1, 16'h0007, 16'h0007, 32'hFFFF_FFCF);
        do_op("mult 0x-1 inj",   16'h0000, 16'hFFFF, 1'b1, 1'b0, 10, 16'h0000, 16'h0001, 32'h0000_0000);

        // HI/LO hold while idle.
        repeat (5) @(negedge Clk);
        check("hold hilo", {hi, lo}, 32'h0000_0000);

        // Set a nonzero HI/LO, then abort a 7x9 mid-WAIT with reset.
        do_op("multu 3x3",       16'h0003, 16'h0003, 1'b0, 1'b0, -1, 16'h0003, 16'h0003, 32'h0000_0009);
        @(negedge Clk);
        req = 1'b1; signed_op = 1'b0; op_a = 16'h0007; op_b = 16'h0009;
        @(negedge Clk);
        req = 1'b0;
        repeat (6) @(negedge Clk);
        check("abort busy before", {31'h0, busy}, 32'h1);
        Reset = 1'b1;
        #1;
        check("abort busy",   {31'h0, busy},   32'h0);
        check("abort mul_st", {31'h0, mul_st}, 32'h0);
        check("abort hilo",   {hi, lo},        32'h0);
        check("abort mul_a",  {16'h0, mul_a},  32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        do_op("multu 2x2",       16'h0002, 16'h0002, 1'b0, 1'b0, -1, 16'h0002, 16'h0002, 32'h0000_0004);

`ifdef MULT_ACC_EN
        do_op("acc base",        16'h0010, 16'h0010, 1'b0, 1'b0, -1, 16'h0010, 16'h0010, 32'h0000_0100);
        do_op("acc maddu",       16'hFFFF, 16'hFFFF, 1'b0, 1'b1, -1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0101);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
- Front-end and back-end stage wrapped around the 16x16 sequential shift-add multiplier.
- Accepts MULT/MULTU requests from the execute stage.
- Converts signed operands to magnitudes, drives the multiplier's start/operand inputs, and waits the fixed multiplier latency.
- Re-applies the sign, then captures the 32-bit result into HI/LO registers read by MFHI/MFLO.

Parameters:
- MUL_LATENCY, 34, cycles from multiplier start pulse until its product output is valid and stable (min 2).
- CNT_W, 6, width of the internal latency counter; must satisfy 2**CNT_W > MUL_LATENCY.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req  in  1  request pulse; sampled only in IDLE.
- signed_op  in  1  1 = MULT (two's complement), 0 = MULTU.
- op_a  in  16  multiplicand (rs).
- op_b  in  16  multiplier (rt).
- busy  out  1  high from the cycle after an accepted req until the DONE cycle inclusive.
- done  out  1  one-cycle pulse; hi/lo are updated in the same cycle.
- hi  out  16  HI register (product[31:16]).
- lo  out  16  LO register (product[15:0]).
- mul_a  out  16  magnitude operand to the multiplier's multiplicand input.
- mul_b  out  16  magnitude operand to the multiplier's multiplier input.
- mul_st  out  1  start pulse to the multiplier.
- mul_p  in  32  product from the multiplier.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, busy=0, done=0, mul_st=0, mul_a=0, mul_b=0, hi=0, lo=0, neg flag=0. An aborted operation leaves no trace. The multiplier shares Reset, so it is also cleared.
- IDLE: req=1 -> latch operands:
  - mul_a = |op_a| if signed_op and op_a[15], else op_a. mul_b likewise.
  - neg = signed_op & (op_a[15] ^ op_b[15]).
  - Go to START.
  - |0x8000| = 0x8000, treated as unsigned 32768. No overflow.
- START: mul_st=1 for exactly one cycle. counter loads MUL_LATENCY-1. Go to WAIT.
- WAIT: counter decrements each cycle. At counter==0 go to CAPTURE. mul_a and mul_b are held stable for the whole operation.
- CAPTURE: result = neg ? (~mul_p + 1) : mul_p, 32-bit wrap. Register {hi,lo}=result. done=1 this cycle. Return to IDLE next cycle.
- Latency: req accepted at edge N -> done high in cycle N+MUL_LATENCY+2. Back-to-back requests are accepted the cycle after done.
- req while busy: ignored, not queued. Operands changing while busy: no effect.
- req and Reset together: Reset wins.
- Zero operand with negative sign yields 0; the negated zero stays 0.
- hi/lo hold their value between operations.

Optional Feature:
- Macro: MULT_ACC_EN.
- Defined: adds input acc (1 bit), sampled with req. When acc=1, CAPTURE writes {hi,lo} = {hi,lo} + result, 32-bit modulo, no carry-out (MADD/MADDU).
- Undefined: no acc port; CAPTURE always overwrites {hi,lo}.

Decomposition:
- Shared package holds:
  - state enum (IDLE, START, WAIT, CAPTURE), 2 bits;
  - DATA_W=16 and PROD_W=32 constants;
  - the default MUL_LATENCY constant, shared with the multiplier's documentation.
- One natural sub-module: sign_mag16, combinational abs value plus sign-bit out. It is instantiated twice.
- Negation and the optional accumulate stay inline.

Test Plan:
- MULTU 0x0003 x 0x0005 -> mul_a=3, mul_b=5, one mul_st pulse; done at N+36 (default); hi=0x0000, lo=0x000F.
- MULT 0xFFFE (-2) x 0x0003 -> mul_a=0x0002; hi=0xFFFF, lo=0xFFFA.
- MULTU 0xFFFF x 0xFFFF -> hi=0xFFFE, lo=0x0001. Then MULT 0x8000 x 0x8000 -> hi=0x4000, lo=0x0000.
- MULT 0x0000 x 0xFFFF -> hi=lo=0x0000. Then req pulsed mid-WAIT with other operands -> ignored; exactly one done.
- Reset asserted during WAIT of a 7x9 op -> immediate busy=0, mul_st=0, hi=lo=0. Next req 2x2 -> lo=0x0004.
- MULT_ACC_EN build: MULTU 0x0010 x 0x0010 then acc=1 MULTU 0xFFFF x 0xFFFF -> {hi,lo}=0xFFFE0101.
